// File: rtl/flash_crc_pkg.sv
// Shared constants, FSM state type and the reflected CRC-32 byte update
// used by the flash readback checker.
package flash_crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } crc_state_t;

    localparam int unsigned STATUS_BUSY    = 0;
    localparam int unsigned STATUS_MATCH   = 1;
    localparam int unsigned STATUS_TIMEOUT = 2;
    localparam int unsigned STATUS_STRAY   = 3;

    // LSB-first update: fold the byte into the low bits, then 8 shift/XOR steps.
    function automatic logic [31:0] crc32_byte_poly(input logic [31:0] crc,
                                                     input logic [7:0]  d,
                                                     input logic [31:0] poly);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        return crc32_byte_poly(crc, d, CRC32_POLY_REFL);
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational one-byte CRC-32 update around the package function.
module crc32_byte_step
    import flash_crc_pkg::*;
#(
    parameter logic [31:0] Poly = CRC32_POLY_REFL
) (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc32_byte_poly(crc_i, data_i, Poly);
    end

endmodule

// File: rtl/flash_readback_crc.sv
// Streaming CRC-32 checker tapping the flash controller read byte path;
// counts a programmed number of bytes and compares against an expected CRC.
module flash_readback_crc
    import flash_crc_pkg::*;
#(
    parameter logic [31:0] CRC_POLY       = 32'hEDB88320,
    parameter logic [31:0] CRC_INIT       = 32'hFFFFFFFF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] length,
    input  logic [31:0] expected_crc,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] crc_out,
    output logic [31:0] byte_count,
    output logic [3:0]  status
);

    crc_state_t  state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] exp_q, exp_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] count_q, count_d;
    logic [23:0] gap_q, gap_d;
    logic [31:0] crc_out_q, crc_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        timeout_q, timeout_d;
    logic        stray_q, stray_d;

    logic [31:0] crc_step;
    logic [31:0] count_inc;
    logic [23:0] gap_inc;
    logic [31:0] exp_src;
    logic        fin;
    logic        fin_timeout;
    logic [31:0] fin_crc;

    crc32_byte_step #(
        .Poly (CRC_POLY)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (byte_data),
        .crc_o  (crc_step)
    );

    assign count_inc = count_q + 32'd1;
    assign gap_inc   = (gap_q == 24'hFFFFFF) ? gap_q : gap_q + 24'd1;
    // A zero-length start finishes in the same cycle, before expected_crc is latched.
    assign exp_src   = start ? expected_crc : exp_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        exp_d       = exp_q;
        crc_d       = crc_q;
        count_d     = count_q;
        gap_d       = gap_q;
        crc_out_d   = crc_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        match_d     = match_q;
        timeout_d   = timeout_q;
        stray_d     = stray_q;
        fin         = 1'b0;
        fin_timeout = 1'b0;
        fin_crc     = crc_q;

        if (start) begin
            len_d     = length;
            exp_d     = expected_crc;
            crc_d     = CRC_INIT;
            count_d   = 32'd0;
            gap_d     = 24'd0;
            crc_out_d = 32'd0;
            match_d   = 1'b0;
            timeout_d = 1'b0;
            // A byte coincident with start is never consumed.
            stray_d   = byte_valid;
            if (length == 32'd0) begin
                fin     = 1'b1;
                fin_crc = CRC_INIT;
            end else begin
                state_d = StRun;
                busy_d  = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (byte_valid) begin
                        crc_d   = crc_step;
                        count_d = count_inc;
                        gap_d   = 24'd0;
                        if (count_inc == len_q) begin
                            fin     = 1'b1;
                            fin_crc = crc_step;
                        end
                    end else begin
                        gap_d = gap_inc;
                        if (gap_inc >= TIMEOUT_CYCLES) begin
                            fin         = 1'b1;
                            fin_timeout = 1'b1;
                        end
                    end
                end
                StFinish: begin
                    state_d = StIdle;
                    stray_d = stray_q | byte_valid;
                end
                default: begin
                    stray_d = stray_q | byte_valid;
                end
            endcase
        end

        // Results are registered on entry so they are valid during the FINISH cycle.
        if (fin) begin
            state_d   = StFinish;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            crc_out_d = fin_crc ^ CRC32_XOROUT;
            timeout_d = fin_timeout;
            match_d   = ((fin_crc ^ CRC32_XOROUT) == exp_src) && !fin_timeout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            len_q     <= 32'd0;
            exp_q     <= 32'd0;
            crc_q     <= 32'd0;
            count_q   <= 32'd0;
            gap_q     <= 24'd0;
            crc_out_q <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            exp_q     <= exp_d;
            crc_q     <= crc_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            crc_out_q <= crc_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            stray_q   <= stray_d;
        end
    end

    always_comb begin
        status                 = 4'h0;
        status[STATUS_BUSY]    = busy_q;
        status[STATUS_MATCH]   = match_q;
        status[STATUS_TIMEOUT] = timeout_q;
        status[STATUS_STRAY]   = stray_q;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign crc_out    = crc_out_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_flash_readback_crc.sv
// Scoreboard bench for flash_readback_crc: expectations queued at start,
// compared by a monitor whenever done pulses.
module tb_flash_readback_crc;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] length;
    logic [31:0] expected_crc;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        busy;
    logic        done;
    logic [31:0] crc_out;
    logic [31:0] byte_count;
    logic [3:0]  status;

    typedef struct {
        logic [31:0] crc;
        logic        match;
        logic        timeout;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  stim [16];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    int          n_pushed = 0;

    flash_readback_crc #(
        .CRC_POLY       (32'hEDB88320),
        .CRC_INIT       (32'hFFFFFFFF),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .length       (length),
        .expected_crc (expected_crc),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .busy         (busy),
        .done         (done),
        .crc_out      (crc_out),
        .byte_count   (byte_count),
        .status       (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: one data bit at a time, final inversion.
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ stim[i][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    task automatic fill_ascii();
        for (int i = 0; i < 16; i++) stim[i] = 8'h31 + 8'(i);
    endtask

    task automatic push_exp(input logic [31:0] c, input logic m, input logic t,
                            input logic [31:0] cnt);
        exp_t e;
        e.crc = c; e.match = m; e.timeout = t; e.count = cnt;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic do_start(input logic [31:0] len, input logic [31:0] exp, input logic vb);
        @(negedge clk);
        start        = 1'b1;
        length       = len;
        expected_crc = exp;
        byte_valid   = vb;
        byte_data    = 8'hAA;
    endtask

    task automatic drive_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start      = 1'b0;
            byte_valid = 1'b1;
            byte_data  = stim[i];
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Cycles from the last driven input until done is seen; 0 if the bound expires.
    task automatic wait_done(input int bound, output int gap);
        gap = 0;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            start      = 1'b0;
            byte_valid = 1'b0;
            if (done) begin
                gap = n;
                break;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("crc_out", crc_out, e.crc);
                check_eq("match", {31'd0, status[1]}, {31'd0, e.match});
                check_eq("timeout", {31'd0, status[2]}, {31'd0, e.timeout});
                check_eq("byte_count", byte_count, e.count);
                check_eq("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int done_before;
        reset_n      = 1'b0;
        start        = 1'b0;
        length       = 32'd0;
        expected_crc = 32'd0;
        byte_valid   = 1'b0;
        byte_data    = 8'h00;
        fill_ascii();

        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_crc_out", crc_out, 32'd0);
        check_eq("rst_byte_count", byte_count, 32'd0);
        check_eq("rst_status", {28'd0, status}, 32'd0);
        reset_n = 1'b1;
        idle_cycle();

        // "123456789" with the correct reference
        push_exp(32'hCBF43926, 1'b1, 1'b0, 32'd9);
        do_start(32'd9, 32'hCBF43926, 1'b0);
        idle_cycle();
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        drive_bytes(9);
        wait_done(40, gap);
        check_eq("done_latency_a", gap, 32'd1);
        idle_cycle();
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        check_eq("crc_out_hold", crc_out, 32'hCBF43926);
        check_eq("byte_count_hold", byte_count, 32'd9);

        // Same bytes, wrong reference
        push_exp(32'hCBF43926, 1'b0, 1'b0, 32'd9);
        do_start(32'd9, 32'h00000000, 1'b0);
        drive_bytes(9);
        wait_done(40, gap);
        check_eq("done_latency_b", gap, 32'd1);

        // Zero length
        push_exp(32'h00000000, 1'b1, 1'b0, 32'd0);
        do_start(32'd0, 32'h00000000, 1'b0);
        wait_done(40, gap);
        check_eq("done_latency_len0", gap, 32'd1);
        idle_cycle();

        // Timeout: three zero bytes of four, then silence
        for (int i = 0; i < 3; i++) stim[i] = 8'h00;
        push_exp(model_crc(3), 1'b0, 1'b1, 32'd3);
        do_start(32'd4, 32'h00000000, 1'b0);
        drive_bytes(3);
        wait_done(60, gap);
        check_eq("done_latency_timeout", gap, 32'd17);
        fill_ascii();
        idle_cycle();

        // Stray bytes in idle, on start, then restart mid-run
        drive_bytes(2);
        idle_cycle();
        check_eq("stray_idle", {31'd0, status[3]}, 32'd1);
        do_start(32'd9, 32'hCBF43926, 1'b1);
        idle_cycle();
        check_eq("stray_on_start", {31'd0, status[3]}, 32'd1);
        done_before = n_done;
        drive_bytes(2);
        push_exp(32'hCBF43926, 1'b1, 1'b0, 32'd9);
        do_start(32'd9, 32'hCBF43926, 1'b0);
        idle_cycle();
        check_eq("stray_cleared", {31'd0, status[3]}, 32'd0);
        drive_bytes(9);
        wait_done(40, gap);
        check_eq("done_latency_restart", gap, 32'd1);
        repeat (3) idle_cycle();
        check_eq("restart_done_count", n_done - done_before, 32'd1);

        // Asynchronous reset in the middle of a run
        done_before = n_done;
        do_start(32'd9, 32'hCBF43926, 1'b0);
        drive_bytes(4);
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_crc_out", crc_out, 32'd0);
        check_eq("midrst_byte_count", byte_count, 32'd0);
        check_eq("midrst_status", {28'd0, status}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) idle_cycle();
        check_eq("midrst_no_done", n_done - done_before, 32'd0);

        // Normal run after reset over random bytes
        for (int i = 0; i < 6; i++) stim[i] = 8'($urandom);
        push_exp(model_crc(6), 1'b1, 1'b0, 32'd6);
        do_start(32'd6, model_crc(6), 1'b0);
        drive_bytes(6);
        wait_done(40, gap);
        check_eq("done_latency_random", gap, 32'd1);

        repeat (5) idle_cycle();
        check_eq("sb_empty", sb.size(), 32'd0);
        check_eq("total_dones", n_done, n_pushed);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
